// File: rtl/csh_pkg.sv
// csh_pkg: shared constants, types and helpers for the MBOX cache directory.
//   PA_W/SETS/WORDS/TAG_W size the directory; a physical address splits into
//   tag = pa[21:9], set = pa[8:2], word = pa[1:0].
package csh_pkg;

  localparam int PA_W   = 22;
  localparam int SETS   = 128;
  localparam int WORDS  = 4;
  localparam int TAG_W  = 13;
  localparam int WAYS   = 4;
  localparam int SET_W  = $clog2(SETS);
  localparam int WORD_W = $clog2(WORDS);
  localparam int WAY_W  = $clog2(WAYS);

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [SET_W-1:0]  set_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [WAY_W-1:0]  way_t;

  typedef struct packed {
    tag_t             tag;
    logic             par;
    logic [WORDS-1:0] valid;
  } dir_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  // Odd parity: the stored bit makes tag plus parity hold an odd number of ones.
  function automatic logic tag_par(input tag_t t);
    return ~(^t);
  endfunction

endpackage

// File: rtl/csh_sweep.sv
// csh_sweep: whole-cache invalidate sequencer.
//   clk, rst     : clock, asynchronous active-high reset
//   start_i      : begin a sweep (ignored unless idle)
//   sweep_busy_o : high for exactly SETS cycles while sets are being cleared
//   sweep_done_o : one-cycle pulse after the last set is cleared
//   clr_en_o     : clear the valid bits of set clr_set_o this cycle
//   clr_set_o    : set being cleared
//   state_o      : current FSM state (debug visibility)
module csh_sweep
  import csh_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             sweep_busy_o,
  output logic             sweep_done_o,
  output logic             clr_en_o,
  output logic [SET_W-1:0] clr_set_o,
  output logic [1:0]       state_o
);

  sweep_state_t state_q, state_d;
  set_t         cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        // The last set is cleared in this same cycle before moving to DONE.
        if (cnt_q == set_t'(SETS - 1)) state_d = DONE;
        else                           cnt_d   = cnt_q + set_t'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sweep_busy_o = (state_q == SWEEP);
  assign sweep_done_o = (state_q == DONE);
  assign clr_en_o     = (state_q == SWEEP);
  assign clr_set_o    = cnt_q;
  assign state_o      = state_q;

endmodule

// File: rtl/csh_dir.sv
// csh_dir: 4-way cache directory for the MBOX cache path.
//   Lookup : lkp_req/lkp_pa accepted when lkp_rdy; one cycle later rsp_vld
//            pulses with valid_match, wd_val, hit, hit_way, victim_way and
//            adr_par_bad. Results hold their value while rsp_vld is low.
//   Fill   : fill_req writes set/tag of fill_pa into fill_way; fill_new picks
//            replace (tag, parity, valid := wmask) vs OR of fill_wmask.
//            par_inject stores inverted parity.
//   Sweep  : sweep_start clears every valid bit, one set per cycle;
//            sweep_busy / sweep_done report progress.
// Handshake: a lookup transfers on a rising edge where lkp_req && lkp_rdy;
//   lkp_rdy drops while a sweep runs or a fill is requested (sweep > fill >
//   lookup), and a fill during sweep_busy is dropped.
module csh_dir
  import csh_pkg::*;
(
  input  logic             clk,
  input  logic             CROBAR,
  input  logic             lkp_req,
  input  logic [PA_W-1:0]  lkp_pa,
  output logic             lkp_rdy,
  output logic             rsp_vld,
  output logic [WAYS-1:0]  valid_match,
  output logic [WAYS-1:0]  wd_val,
  output logic             hit,
  output logic [1:0]       hit_way,
  output logic [1:0]       victim_way,
  output logic             adr_par_bad,
  input  logic             fill_req,
  input  logic [1:0]       fill_way,
  input  logic [PA_W-1:0]  fill_pa,
  input  logic [WORDS-1:0] fill_wmask,
  input  logic             fill_new,
  input  logic             par_inject,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done
);

  // Tags and parity are never reset; valid bits and pointers are.
  tag_t                                 tag_q [SETS][WAYS];
  logic                                 par_q [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0][WORDS-1:0] valid_q;
  logic [SETS-1:0][WAY_W-1:0]           ptr_q;

  logic       clr_en;
  set_t       clr_set;
  logic [1:0] sweep_state;

  csh_sweep u_sweep (
    .clk          (clk),
    .rst          (CROBAR),
    .start_i      (sweep_start),
    .sweep_busy_o (sweep_busy),
    .sweep_done_o (sweep_done),
    .clr_en_o     (clr_en),
    .clr_set_o    (clr_set),
    .state_o      (sweep_state)
  );

  // Word bits of fill_pa carry no directory information; FSM state is debug only.
  logic unused_bits;
  assign unused_bits = ^{fill_pa[WORD_W-1:0], sweep_state};

  assign lkp_rdy = !sweep_busy && !fill_req;

  logic lkp_acc, fill_wr;
  assign lkp_acc = lkp_req && lkp_rdy;
  assign fill_wr = fill_req && !sweep_busy;

  set_t  lkp_set, fill_set;
  word_t lkp_word;
  tag_t  lkp_tag, fill_tag;
  assign lkp_set  = lkp_pa[SET_W+WORD_W-1:WORD_W];
  assign lkp_word = lkp_pa[WORD_W-1:0];
  assign lkp_tag  = lkp_pa[PA_W-1:PA_W-TAG_W];
  assign fill_set = fill_pa[SET_W+WORD_W-1:WORD_W];
  assign fill_tag = fill_pa[PA_W-1:PA_W-TAG_W];

  logic [WAYS-1:0] vm_c, wd_c;
  logic            pb_c, hit_c;
  way_t            hw_c, vic_c;

  always_comb begin
    dir_entry_t ent;
    vm_c = '0;
    wd_c = '0;
    pb_c = 1'b0;
    hw_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      ent.tag   = tag_q[lkp_set][w];
      ent.par   = par_q[lkp_set][w];
      ent.valid = valid_q[lkp_set][w];
      vm_c[w]   = (|ent.valid) && (ent.tag == lkp_tag);
      wd_c[w]   = vm_c[w] && ent.valid[lkp_word];
      if (vm_c[w] && (ent.par != tag_par(ent.tag))) pb_c = 1'b1;
    end
    // Descending scan leaves the lowest hitting way.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (wd_c[w]) hw_c = way_t'(w);
    end
    hit_c = (|wd_c) && !pb_c;
    if (!hit_c) hw_c = '0;
    vic_c = hit_c ? hw_c : ptr_q[lkp_set];
  end

  always_ff @(posedge clk) begin
    if (fill_wr && fill_new) begin
      tag_q[fill_set][fill_way] <= fill_tag;
      par_q[fill_set][fill_way] <= tag_par(fill_tag) ^ par_inject;
    end
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (clr_en) begin
      valid_q[clr_set] <= '0;
    end else if (fill_wr) begin
      if (fill_new) valid_q[fill_set][fill_way] <= fill_wmask;
      else          valid_q[fill_set][fill_way] <= valid_q[fill_set][fill_way] | fill_wmask;
      // Pointer only advances when the line it names is replaced.
      if (fill_new && (fill_way == ptr_q[fill_set]))
        ptr_q[fill_set] <= ptr_q[fill_set] + way_t'(1);
    end
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      rsp_vld     <= 1'b0;
      valid_match <= '0;
      wd_val      <= '0;
      hit         <= 1'b0;
      hit_way     <= '0;
      victim_way  <= '0;
      adr_par_bad <= 1'b0;
    end else begin
      rsp_vld <= lkp_acc;
      if (lkp_acc) begin
        valid_match <= vm_c;
        wd_val      <= wd_c;
        hit         <= hit_c;
        hit_way     <= hw_c;
        victim_way  <= vic_c;
        adr_par_bad <= pb_c;
      end
    end
  end

  // Two ways holding the same valid tag is a fill-sequencing bug upstream.
  a_vm_onehot: assert property (@(posedge clk) disable iff (CROBAR)
    lkp_acc |-> $onehot0(vm_c));

endmodule
